clock_request_fanin: RTL and testbench
======================================

# clock_request_fanin

Merges clock requests from several downstream consumers into the single `child_request` / status handshake of one clock node. Each consumer sees its own `ready/silent/starting/stopping` view. A programmable hold-off timer stops the clock from being toggled off and on again by bursty consumers. The block sits directly downstream of the clock node's child port: its `parent_*` side connects there, and its `child_*` side fans out to gated leaf logic.

## Interface
- `NUM_CHILDREN`, default 4: consumer count, legal range 1..16.
- `HOLD_CYCLES`, default 16: idle cycles before the parent request is released, legal range 0..255.
- `clock  input  1`: the single clock; all logic is synchronous to its rising edge.
- `reset  input  1`: synchronous, active-high.
- `parent_request  output  1`: clock request to the node upstream.
- `parent_ready  input  1`: the upstream clock is running and stable.
- `parent_silent  input  1`: the upstream clock is fully stopped.
- `parent_starting  input  1`: the upstream clock is ramping up. Informational only.
- `parent_stopping  input  1`: the upstream clock is ramping down. Informational only.
- `child_request  input  NUM_CHILDREN`: per-consumer request, level.
- `child_ready  output  NUM_CHILDREN`: per-consumer clock-usable indication.
- `child_silent  output  NUM_CHILDREN`: per-consumer clock-stopped indication.
- `child_starting  output  NUM_CHILDREN`: per-consumer wake-in-progress indication.
- `child_stopping  output  NUM_CHILDREN`: per-consumer sleep-in-progress indication.

## Operation
- The FSM has five states: OFF, WAKING, ON, HOLD, SLEEPING.
- Let `any_req` be the OR-reduction of `child_request`.
- OFF: if `any_req && parent_silent`, go to WAKING. A request that arrives while the parent is not yet silent waits in OFF.
- WAKING: when `parent_ready`, go to ON.
  - A wake is never aborted. If all requests drop during WAKING, the block still reaches ON and then follows the ON rules.
- ON: when `!any_req`, go to HOLD and load the hold counter with `HOLD_CYCLES-1`. If `HOLD_CYCLES==0`, go directly to SLEEPING instead.
- HOLD:
  - If `any_req`, return to ON. The counter is discarded.
  - Otherwise, if the counter is 0, go to SLEEPING.
  - Otherwise, decrement the counter.
- SLEEPING: when `parent_silent`, go to OFF. Requests that arrive during SLEEPING wait, and the block re-wakes from OFF.
- `parent_request` is 1 in WAKING, ON and HOLD, and 0 in OFF and SLEEPING.
- `child_ready[i]` = (state is ON or HOLD) && `parent_ready` && `child_request[i]`.
- `child_starting[i]` = (state is WAKING) && `child_request[i]`.
- `child_stopping[i]` = (state is SLEEPING).
- `child_silent[i]` = (state is OFF) || ((state is ON or HOLD) && !`child_request[i]`).
- For each child, at most one of `child_ready`, `child_silent`, `child_starting`, `child_stopping` is set in any cycle.
- The hold counter is 8 bits wide and unsigned. It never underflows: the transition at 0 takes priority over the decrement.

## Timing
- Every output is a flop. The reset value of every output is 0, except `child_silent`, which resets to all-ones. The FSM resets to OFF and the counter to 0.
- An input change is visible on the outputs one cycle after the sampling edge.
  - Example: a `child_request` rise in OFF with `parent_silent` asserts `parent_request` and `child_starting` at edge+1.
- An ON→HOLD→SLEEPING sequence with no requests takes `HOLD_CYCLES` cycles in HOLD. `parent_request` falls `HOLD_CYCLES+1` cycles after the last request falls.
- Simultaneous events:
  - In HOLD, a request arriving in the same cycle as counter==0 wins, and the next state is ON.
  - In SLEEPING, `parent_silent` together with `any_req` goes to OFF. WAKING follows on the next cycle, provided `parent_silent` is still set.
- If reset is asserted mid-operation in any state, the next edge returns the block to reset values and `parent_request` drops immediately. The upstream node tolerates this drop.

## Structure
- The state enum `clock_fanin_state_e` lives in the shared `clock_pkg`. The package also holds the `CLOCK_HOLD_W = 8` constant.
- The hold-off counter is a sub-module, `clock_hold_timer`, with ports `load`, `load_value`, `clear`, `tick` and `expired`. The FSM and the per-child output decode stay in the top module.
- The top module is purely synchronous: no latches and no clock gating inside this block.

## Test plan
- **Wake from reset.** `NUM_CHILDREN=4`, `parent_silent=1`, raise `child_request=4'b0010`.
  - `parent_request=1` and `child_starting=4'b0010` at +1.
  - Drive `parent_ready=1`; `child_ready=4'b0010` at +1.
  - All other children read silent throughout.
- **Hold expiry.** `HOLD_CYCLES=16`, in ON, drop all requests.
  - `parent_request` stays 1 for 16 HOLD cycles and falls at cycle 17.
  - `child_stopping=4'hF` until `parent_silent`, then `child_silent=4'hF`.
- **Hold rescue.** Same as hold expiry, but re-raise `child_request[0]` exactly when the counter reaches 0.
  - The FSM returns to ON.
  - `parent_request` never drops.
  - `child_ready[0]=1` on the next cycle.
- **Request during SLEEPING.** Raise `child_request[3]` while the parent is stopping.
  - The block stays in SLEEPING until `parent_silent`, passes through OFF, then enters WAKING.
  - `parent_request` is low for at least 2 cycles.
- **Zero hold and reset mid-WAKING.** With `HOLD_CYCLES=0`, drop all requests in ON: the next state is SLEEPING immediately. Separately, assert `reset` during WAKING: all outputs return to their reset values one edge later.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared fan-in FSM state enum and hold-off counter width
package clock_pkg;
  localparam int CLOCK_HOLD_W = 8;
  typedef enum logic [2:0] {ST_OFF, ST_WAKING, ST_ON, ST_HOLD, ST_SLEEPING} clock_fanin_state_e;
endpackage

// File: rtl/clock_hold_timer.sv
// clock_hold_timer: hold-off down-counter (load presets load_value, clear zeroes, tick decrements, expired when zero)
module clock_hold_timer import clock_pkg::*; (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [CLOCK_HOLD_W-1:0] load_value,
  input  logic                    clear,
  input  logic                    tick,
  output logic                    expired
);
  logic [CLOCK_HOLD_W-1:0] count;
  assign expired = count == '0;
  always_ff @(posedge clock)
    if (reset || clear) count <= '0;
    else if (load) count <= load_value;
    else if (tick && !expired) count <= count - CLOCK_HOLD_W'(1);
endmodule

// File: rtl/clock_request_fanin.sv
// clock_request_fanin: merges child_request into one parent_request with hold-off; ports parent_* to clock node, child_* per consumer, all outputs flopped
module clock_request_fanin import clock_pkg::*; #(
  parameter int NUM_CHILDREN = 4,
  parameter int HOLD_CYCLES  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    parent_request,
  input  logic                    parent_ready,
  input  logic                    parent_silent,
  input  logic                    parent_starting,
  input  logic                    parent_stopping,
  input  logic [NUM_CHILDREN-1:0] child_request,
  output logic [NUM_CHILDREN-1:0] child_ready,
  output logic [NUM_CHILDREN-1:0] child_silent,
  output logic [NUM_CHILDREN-1:0] child_starting,
  output logic [NUM_CHILDREN-1:0] child_stopping
);
  localparam logic [CLOCK_HOLD_W-1:0] HOLD_LOAD = CLOCK_HOLD_W'(HOLD_CYCLES == 0 ? 0 : HOLD_CYCLES - 1);
  clock_fanin_state_e state, state_next;
  logic any_req, hold_load, hold_clear, hold_tick, hold_expired, next_awake;
  logic unused_info;
  assign unused_info = parent_starting | parent_stopping;
  assign any_req = |child_request;
  assign hold_load = state == ST_ON && !any_req && HOLD_CYCLES != 0;
  assign hold_clear = state == ST_HOLD && any_req;
  assign hold_tick = state == ST_HOLD && !any_req;
  assign next_awake = state_next == ST_ON || state_next == ST_HOLD;
  clock_hold_timer u_timer (
    .clock(clock),
    .reset(reset),
    .load(hold_load),
    .load_value(HOLD_LOAD),
    .clear(hold_clear),
    .tick(hold_tick),
    .expired(hold_expired)
  );
  always_comb begin
    state_next = state;
    case (state)
      ST_OFF:      state_next = any_req && parent_silent ? ST_WAKING : ST_OFF;
      ST_WAKING:   state_next = parent_ready ? ST_ON : ST_WAKING;
      ST_ON:       state_next = any_req ? ST_ON : HOLD_CYCLES == 0 ? ST_SLEEPING : ST_HOLD;
      ST_HOLD:     state_next = any_req ? ST_ON : hold_expired ? ST_SLEEPING : ST_HOLD;
      ST_SLEEPING: state_next = parent_silent ? ST_OFF : ST_SLEEPING;
      default:     state_next = ST_OFF;
    endcase
  end
  // outputs are registered from the next state so they settle one edge after the inputs are sampled
  always_ff @(posedge clock)
    if (reset) begin
      state          <= ST_OFF;
      parent_request <= 1'b0;
      child_ready    <= '0;
      child_silent   <= '1;
      child_starting <= '0;
      child_stopping <= '0;
    end else begin
      state          <= state_next;
      parent_request <= state_next == ST_WAKING || next_awake;
      child_ready    <= next_awake && parent_ready ? child_request : '0;
      child_silent   <= state_next == ST_OFF ? '1 : next_awake ? ~child_request : '0;
      child_starting <= state_next == ST_WAKING ? child_request : '0;
      child_stopping <= state_next == ST_SLEEPING ? '1 : '0;
    end
endmodule

// File: tb/tb_clock_request_fanin.sv
// tb_clock_request_fanin: scoreboard bench for two fan-in instances (hold 16 and hold 0) against a phase/idle-count model
module tb_clock_request_fanin;
  localparam int N = 4;
  localparam int HA = 16;
  localparam int HB = 0;
  typedef struct packed {
    logic         preq;
    logic [N-1:0] rdy;
    logic [N-1:0] sil;
    logic [N-1:0] st;
    logic [N-1:0] sp;
  } exp_t;
  typedef struct {
    int phase;
    int idle;
  } ms_t;
  localparam int P_OFF = 0, P_WAKE = 1, P_AWAKE = 2, P_SLEEP = 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic parent_ready = 1'b0, parent_silent = 1'b1, parent_starting = 1'b0, parent_stopping = 1'b0;
  logic [N-1:0] child_request = '0;
  logic a_preq, b_preq;
  logic [N-1:0] a_rdy, a_sil, a_st, a_sp, b_rdy, b_sil, b_st, b_sp;
  exp_t qa[$], qb[$];
  ms_t ma, mb;
  int checks = 0, fails = 0;
  logic want = 1'b0;
  always #5 clock = ~clock;
  clock_request_fanin #(.NUM_CHILDREN(N), .HOLD_CYCLES(HA)) dut_a (
    .clock(clock), .reset(reset), .parent_request(a_preq), .parent_ready(parent_ready),
    .parent_silent(parent_silent), .parent_starting(parent_starting), .parent_stopping(parent_stopping),
    .child_request(child_request), .child_ready(a_rdy), .child_silent(a_sil),
    .child_starting(a_st), .child_stopping(a_sp)
  );
  clock_request_fanin #(.NUM_CHILDREN(N), .HOLD_CYCLES(HB)) dut_b (
    .clock(clock), .reset(reset), .parent_request(b_preq), .parent_ready(parent_ready),
    .parent_silent(parent_silent), .parent_starting(parent_starting), .parent_stopping(parent_stopping),
    .child_request(child_request), .child_ready(b_rdy), .child_silent(b_sil),
    .child_starting(b_st), .child_stopping(b_sp)
  );
  // awake phase covers ON and HOLD; sleep begins once more than hold consecutive idle edges were seen
  function automatic exp_t mstep(input int hold, inout ms_t s, input logic r, input logic [N-1:0] req,
                                 input logic rdy, input logic sil);
    exp_t e;
    if (r) begin
      s.phase = P_OFF;
      s.idle = 0;
    end else if (s.phase == P_OFF) begin
      if (req != 0 && sil) s.phase = P_WAKE;
    end else if (s.phase == P_WAKE) begin
      if (rdy) begin
        s.phase = P_AWAKE;
        s.idle = 0;
      end
    end else if (s.phase == P_AWAKE) begin
      if (req != 0) s.idle = 0;
      else begin
        s.idle++;
        if (s.idle > hold) s.phase = P_SLEEP;
      end
    end else if (sil) s.phase = P_OFF;
    e.preq = s.phase == P_WAKE || s.phase == P_AWAKE;
    e.rdy = (s.phase == P_AWAKE && rdy) ? req : '0;
    e.st = s.phase == P_WAKE ? req : '0;
    e.sp = s.phase == P_SLEEP ? '1 : '0;
    e.sil = s.phase == P_OFF ? '1 : s.phase == P_AWAKE ? ~req : '0;
    return e;
  endfunction
  task automatic step(input logic r, input logic [N-1:0] req, input logic rdy, input logic sil,
                      input logic st, input logic sp);
    exp_t ea, eb;
    @(negedge clock);
    reset = r;
    child_request = req;
    parent_ready = rdy;
    parent_silent = sil;
    parent_starting = st;
    parent_stopping = sp;
    @(posedge clock);
    ea = mstep(HA, ma, r, req, rdy, sil);
    eb = mstep(HB, mb, r, req, rdy, sil);
    want = ea.preq;
    qa.push_back(ea);
    qb.push_back(eb);
  endtask
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cmp(input string tag, input exp_t act, input exp_t e);
    chk({tag, "_parent_request"}, N'(act.preq), N'(e.preq));
    chk({tag, "_child_ready"}, act.rdy, e.rdy);
    chk({tag, "_child_silent"}, act.sil, e.sil);
    chk({tag, "_child_starting"}, act.st, e.st);
    chk({tag, "_child_stopping"}, act.sp, e.sp);
    for (int i = 0; i < N; i++)
      chk({tag, "_onehot0"}, N'($onehot0({act.rdy[i], act.sil[i], act.st[i], act.sp[i]})), N'(1));
  endtask
  always @(negedge clock) begin
    if (qa.size() > 0) cmp("a", {a_preq, a_rdy, a_sil, a_st, a_sp}, qa.pop_front());
    if (qb.size() > 0) cmp("b", {b_preq, b_rdy, b_sil, b_st, b_sp}, qb.pop_front());
  end
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int ramp, quiet;
    logic up_on, r;
    logic [N-1:0] req;
    ma.phase = P_OFF; ma.idle = 0;
    mb.phase = P_OFF; mb.idle = 0;
    repeat (3) step(1, 4'b0000, 0, 1, 0, 0);
    // wake from reset
    step(0, 4'b0010, 0, 1, 0, 0);
    step(0, 4'b0010, 0, 0, 1, 0);
    step(0, 4'b0010, 1, 0, 0, 0);
    repeat (3) step(0, 4'b0010, 1, 0, 0, 0);
    // hold expiry, then ramp-down and silence
    repeat (18) step(0, 4'b0000, 1, 0, 0, 0);
    repeat (3) step(0, 4'b0000, 0, 0, 0, 1);
    repeat (2) step(0, 4'b0000, 0, 1, 0, 0);
    // hold rescue exactly at counter zero
    step(0, 4'b0001, 0, 1, 0, 0);
    step(0, 4'b0001, 1, 0, 0, 0);
    step(0, 4'b0001, 1, 0, 0, 0);
    repeat (16) step(0, 4'b0000, 1, 0, 0, 0);
    repeat (3) step(0, 4'b0001, 1, 0, 0, 0);
    // request during SLEEPING
    repeat (17) step(0, 4'b0000, 1, 0, 0, 0);
    repeat (3) step(0, 4'b1000, 0, 0, 0, 1);
    repeat (3) step(0, 4'b1000, 0, 1, 0, 0);
    // reset mid-WAKING
    step(0, 4'b1000, 0, 0, 1, 0);
    step(1, 4'b1000, 0, 0, 1, 0);
    step(0, 4'b0000, 0, 1, 0, 0);
    // randomized traffic against an emulated upstream node
    up_on = 1'b0; ramp = 0; quiet = 0; req = '0;
    for (int c = 0; c < 3000; c++) begin
      if (ramp > 0) begin
        ramp--;
        if (ramp == 0) up_on = ~up_on;
      end else if (want != up_on) ramp = $urandom_range(1, 4);
      if (quiet > 0) begin
        quiet--;
        req = '0;
      end else if ($urandom_range(0, 63) == 0) quiet = $urandom_range(5, 40);
      else if ($urandom_range(0, 7) == 0) req = $urandom_range(0, 3) == 0 ? '0 : N'($urandom);
      r = $urandom_range(0, 399) == 0;
      step(r, req, up_on && ramp == 0, !up_on && ramp == 0, !up_on && ramp > 0, up_on && ramp > 0);
    end
    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
